// File: rtl/mole_sched.sv
// Whack-a-mole game sequencer: LFSR mole pick, lit window, edge-detected hit/miss judging, score.
// Optional MOLE_SCHED_PENALTY_EN: a wrong-hole press in UP ends the round as a miss and costs a point.
module mole_sched #(
  parameter int         UP_CYCLES  = 8,
  parameter int         GAP_CYCLES = 4,
  parameter int         ROUNDS     = 10,
  parameter logic [4:0] LFSR_SEED  = 5'h1D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] mole,
  output logic [3:0] score,
  output logic       busy,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [1:0] dbg_state
);

  localparam int UW = (UP_CYCLES > 1) ? $clog2(UP_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state, w_state_nx;
  logic [4:0]      r_lfsr;
  logic [3:0]      r_btn_q;
  logic [1:0]      r_prev_idx, w_prev_nx;
  logic [GW-1:0]   r_gap_cnt, w_gap_nx;
  logic [UW-1:0]   r_up_cnt, w_up_nx;
  logic [3:0]      r_round_cnt, w_round_nx;
  logic [3:0]      r_mole, w_mole_nx;
  logic [3:0]      r_score, w_score_nx;
  logic            r_busy, w_busy_nx;
  logic            r_game_over, w_go_nx;
  logic            r_hit, w_hit_nx;
  logic            r_miss, w_miss_nx;

  logic [3:0]      w_edge;
  logic            w_in_up, w_hit, w_wrong, w_timeout, w_end, w_last;
  logic [1:0]      w_idx_raw, w_idx;
  logic [4:0]      w_lfsr_nx;

  assign w_edge    = btn & ~r_btn_q;
  assign w_in_up   = (r_state == S_UP);
  assign w_hit     = w_in_up && |(w_edge & r_mole);
`ifdef MOLE_SCHED_PENALTY_EN
  assign w_wrong   = w_in_up && !w_hit && |(w_edge & ~r_mole);
`else
  assign w_wrong   = 1'b0;
`endif
  assign w_timeout = w_in_up && !w_hit && !w_wrong && (r_up_cnt == '0);
  assign w_end     = w_hit | w_wrong | w_timeout;
  assign w_last    = ((r_round_cnt + 4'd1) == 4'(ROUNDS));

  // Avoid lighting the same hole twice in a row by stepping to the next one.
  assign w_idx_raw = r_lfsr[1:0];
  assign w_idx     = (w_idx_raw == r_prev_idx) ? w_idx_raw + 2'd1 : w_idx_raw;
  assign w_lfsr_nx = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_btn_q     <= 4'd0;
      r_prev_idx  <= 2'd3;
      r_gap_cnt   <= '0;
      r_up_cnt    <= '0;
      r_round_cnt <= 4'd0;
      r_mole      <= 4'd0;
      r_score     <= 4'd0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_lfsr      <= w_lfsr_nx;
      r_btn_q     <= btn;
      r_prev_idx  <= w_prev_nx;
      r_gap_cnt   <= w_gap_nx;
      r_up_cnt    <= w_up_nx;
      r_round_cnt <= w_round_nx;
      r_mole      <= w_mole_nx;
      r_score     <= w_score_nx;
      r_busy      <= w_busy_nx;
      r_game_over <= w_go_nx;
      r_hit       <= w_hit_nx;
      r_miss      <= w_miss_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nx = S_GAP;
      S_GAP:          if (r_gap_cnt == '0) w_state_nx = S_UP;
      S_UP:           if (w_end) w_state_nx = w_last ? S_DONE : S_GAP;
      default:        w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_prev_nx  = r_prev_idx;
    w_gap_nx   = r_gap_cnt;
    w_up_nx    = r_up_cnt;
    w_round_nx = r_round_cnt;
    w_mole_nx  = r_mole;
    w_score_nx = r_score;
    w_busy_nx  = r_busy;
    w_go_nx    = r_game_over;
    w_hit_nx   = 1'b0;
    w_miss_nx  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_score_nx = 4'd0;
          w_round_nx = 4'd0;
          w_gap_nx   = GW'(GAP_CYCLES - 1);
          w_go_nx    = 1'b0;
          w_busy_nx  = 1'b1;
          w_mole_nx  = 4'd0;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_mole_nx = 4'b0001 << w_idx;
          w_prev_nx = w_idx;
          w_up_nx   = UW'(UP_CYCLES - 1);
        end else begin
          w_gap_nx = r_gap_cnt - 1'b1;
        end
      end
      S_UP: begin
        if (w_hit) begin
          w_score_nx = (r_score == 4'hF) ? 4'hF : r_score + 4'd1;
          w_hit_nx   = 1'b1;
        end else if (w_wrong) begin
          w_score_nx = (r_score == 4'd0) ? 4'd0 : r_score - 4'd1;
          w_miss_nx  = 1'b1;
        end else if (w_timeout) begin
          w_miss_nx  = 1'b1;
        end else begin
          w_up_nx    = r_up_cnt - 1'b1;
        end
        if (w_end) begin
          w_mole_nx  = 4'd0;
          w_round_nx = r_round_cnt + 4'd1;
          if (w_last) begin
            w_busy_nx = 1'b0;
            w_go_nx   = 1'b1;
          end else begin
            w_gap_nx  = GW'(GAP_CYCLES - 1);
          end
        end
      end
      default: ;
    endcase
  end

  assign mole       = r_mole;
  assign score      = r_score;
  assign busy       = r_busy;
  assign game_over  = r_game_over;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;
  assign dbg_state  = r_state;

endmodule

// File: doc/mole_sched.md
Name: mole_sched

Overview:
- Game sequencer for the four-hole whack-a-mole datapath.
- Picks a pseudo-random mole, holds it lit for a bounded window, and judges button presses against it as hit or miss.
- Keeps the 4-bit score and runs a fixed number of rounds per game.
- Drives the mole lamps and score display; takes the raw player buttons, which may bounce.

Parameters:
- UP_CYCLES, 8: cycles a mole stays lit if not hit (>=1).
- GAP_CYCLES, 4: dark cycles between moles; also the post-hit lockout (>=1).
- ROUNDS, 10: moles per game (1..15).
- LFSR_SEED, 5'h1D: nonzero reset value of the selection LFSR.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; starts a game when sampled high in IDLE or DONE.
- btn  in  4  raw player buttons, btn[i] = hole i.
- mole  out  4  one-hot lit mole; 0 when none.
- score  out  4  hits this game, saturating.
- busy  out  1  high in GAP or UP.
- game_over  out  1  high in DONE.
- hit_pulse  out  1  one-cycle pulse per hit.
- miss_pulse  out  1  one-cycle pulse per timeout (or penalty).

Behaviour:
- Reset:
  - State IDLE; mole=0, score=0, busy=0, game_over=0, pulses=0.
  - lfsr=LFSR_SEED, btn_q=0, prev_idx=3, counters=0.
- Outputs and state:
  - All outputs registered; no combinational path from inputs to outputs.
  - States: IDLE, GAP, UP, DONE.
- Edge detect:
  - btn_q <= btn every cycle.
  - edge = btn & ~btn_q.
  - Only edges count; held buttons never re-trigger.
- LFSR:
  - 5-bit, taps x^5+x^3+1, shifts every cycle in every state except reset; never reaches 0.
- IDLE/DONE:
  - start=1 -> GAP.
  - Clear score, round_cnt=0, load gap_cnt=GAP_CYCLES-1, game_over=0, busy=1.
- GAP:
  - mole=0. btn edges ignored; this is the debounce lockout.
  - At gap_cnt==0 -> UP.
  - idx=lfsr[1:0]; if idx==prev_idx use idx+1 mod 4 (no immediate repeat).
  - mole=1<<idx, prev_idx=idx, up_cnt=UP_CYCLES-1.
  - Otherwise decrement gap_cnt.
- UP:
  - Hit: edge on the lit hole -> score=min(score+1,15), hit_pulse=1, mole=0, end round.
  - Edges on unlit holes are ignored, unless the optional feature is enabled.
  - Timeout: up_cnt==0 with no hit -> miss_pulse=1, mole=0, end round; otherwise decrement up_cnt.
  - Hit and timeout in the same cycle: hit wins.
  - Latency: edge sampled at clock edge n -> mole=0 and score updated after edge n.
- End round:
  - round_cnt+1.
  - If round_cnt+1==ROUNDS -> DONE (busy=0, game_over=1).
  - Else -> GAP, gap_cnt=GAP_CYCLES-1.
- start is ignored while busy.
- Score saturation: score holds at 15 and hit_pulse still fires.
- Reset mid-game: immediate return to reset values, including mid-UP with mole lit.

Optional Feature:
- Macro: MOLE_SCHED_PENALTY_EN.
- Defined:
  - In UP, an edge on any unlit hole with no simultaneous edge on the lit hole ends the round as a miss.
  - Sets miss_pulse=1, mole=0, score=max(score-1,0).
  - A correct edge in the same cycle takes priority and counts as a hit only.
- Undefined: wrong-hole edges are ignored; score is never decremented.

Test Plan:
- Reset then start=1 for 1 cycle:
  - busy=1 next cycle; mole=0 for 4 cycles, then exactly one mole bit set for 8 cycles.
  - miss_pulse=1 for 1 cycle; score stays 0.
- Press the lit hole on the 3rd UP cycle, bouncing 1,0,1,0,1 over 5 cycles:
  - score=1 and hit_pulse=1 on the cycle after the first rising edge, only once.
  - mole=0 during the bounce; subsequent GAP ignores the bounces.
- Hold the lit button from GAP into UP (no new edge): no hit; round times out with miss_pulse.
- ROUNDS=3, hit all three:
  - score=3; game_over=1, busy=0 after the 3rd hit.
  - start during the game has no effect.
  - start in DONE clears score to 0.
- Across 50 games: no two consecutive moles on the same hole; mole always one-hot or 0.
- Assert rst mid-UP:
  - mole=0, score=0, state IDLE immediately, without waiting for a clock.
- With MOLE_SCHED_PENALTY_EN at score=2:
  - Wrong-hole edge -> score=1, miss_pulse=1.
  - Wrong+right edges in the same cycle -> score=2, hit_pulse=1.
  - Wrong edge at score 0 -> score stays 0.
